// File: rtl/axi_rd_regulator.sv
// AXI4 read-channel regulator: caps outstanding read bursts and charges R beats
// against a per-window budget before letting an AR through; R passes straight across.
module axi_rd_regulator #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int BEAT_BUDGET     = 512
) (
    input  logic              clk_100MHz,
    input  logic              reset_rtl_0,
    input  logic              reg_en,

    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,

    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,

    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,

    output logic [7:0]        outstanding,
    output logic [16:0]       budget_used,
    output logic              throttle,
    output logic [31:0]       stall_cycles
);

    localparam int                WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [7:0]        MAX_OUT  = 8'(MAX_OUTSTANDING);
    localparam logic [17:0]       BUDGET   = 18'(BEAT_BUDGET);

    logic [WIN_W-1:0] win_cnt;
    logic [16:0]      burst_beats;
    logic [17:0]      budget_sum;
    logic             allow;
    logic             gate_ok;
    logic             ar_hs;
    logic             rd_done;
    logic             win_wrap;
    logic             stall_now;

    // Pure wiring paths: AR payload and the whole R channel.
    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;

    assign s_rid     = m_rid;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;

    // allow depends only on registered state and the (held-stable) AR length,
    // so there is no combinational loop through m_arready or s_arvalid.
    assign burst_beats = 17'(s_arlen) + 17'd1;
    assign budget_sum  = {1'b0, budget_used} + {1'b0, burst_beats};
    assign allow       = !reg_en ||
                         ((outstanding < MAX_OUT) &&
                          ((budget_sum <= BUDGET) || (budget_used == 17'd0)));
    assign gate_ok     = allow && !reset_rtl_0;

    assign m_arvalid = s_arvalid && gate_ok;
    assign s_arready = m_arready && gate_ok;

    // Valid/ready: a transfer happens on a channel when valid && ready at a clock edge.
    assign ar_hs     = m_arvalid && m_arready;
    assign rd_done   = m_rvalid && m_rready && m_rlast;
    assign win_wrap  = (win_cnt == WIN_LAST);
    assign stall_now = s_arvalid && !allow;

    always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            outstanding  <= 8'd0;
            budget_used  <= 17'd0;
            win_cnt      <= '0;
            throttle     <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            if (ar_hs && !rd_done) begin
                if (outstanding != 8'hFF)
                    outstanding <= outstanding + 8'd1;
            end else if (!ar_hs && rd_done) begin
                if (outstanding != 8'd0)
                    outstanding <= outstanding - 8'd1;
            end

            // A burst accepted on the wrap cycle is charged to the new window.
            if (win_wrap) begin
                win_cnt     <= '0;
                budget_used <= ar_hs ? burst_beats : 17'd0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (ar_hs)
                    budget_used <= budget_sum[16:0];
            end

            throttle <= stall_now;
            if (stall_now && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
